// File: rtl/lsb_queue_param_pkg.sv
// Shared definitions for the load/store buffer: load/store width codes,
// tag layout, I/O window selector, FSM state type and load extension helpers.
package lsb_queue_param_pkg;

   // Default ROB position width. An operand tag is {pending, rob_pos}:
   // bit ROB_W set means the operand still waits for a CDB broadcast.
   localparam int ROB_W_DEF = 4;

   // addr[17:16] value selecting the I/O window.
   localparam logic [1:0] IO_HI_DEF = 2'b11;

   // RV32 load/store funct3 codes (stores use the B/H/W subset).
   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } lsb_state_t;

   // Access size in bytes for a funct3 code.
   function automatic logic [2:0] len_of(input logic [2:0] funct3);
      logic [2:0] len;
      case (funct3[1:0])
         2'b00:   len = 3'd1;
         2'b01:   len = 3'd2;
         default: len = 3'd4;
      endcase
      return len;
   endfunction

   // Sign/zero extension of low-aligned raw load data.
   function automatic logic [31:0] ext_load(input logic [2:0] funct3, input logic [31:0] data);
      logic [31:0] r;
      case (funct3)
         FUNCT3_B:  r = {{24{data[7]}}, data[7:0]};
         FUNCT3_H:  r = {{16{data[15]}}, data[15:0]};
         FUNCT3_BU: r = {24'h0, data[7:0]};
         FUNCT3_HU: r = {16'h0, data[15:0]};
         default:   r = data;
      endcase
      return r;
   endfunction

   // True when the address falls in the I/O window.
   function automatic logic is_io(input logic [31:0] addr, input logic [1:0] io_hi);
      return (addr[17:16] == io_hi);
   endfunction

endpackage

// File: rtl/lsb_cdb_match.sv
// Compares one operand tag against every result bus; the lowest-numbered
// matching bus supplies the value.
module lsb_cdb_match
   import lsb_queue_param_pkg::*;
#(
   parameter int ROB_W   = ROB_W_DEF,
   parameter int NUM_CDB = 2
) (
   input  logic [ROB_W:0]           tag,
   input  logic [NUM_CDB-1:0]       cdb_valid,
   input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_pos,
   input  logic [NUM_CDB*32-1:0]    cdb_val,
   output logic                     hit,
   output logic [31:0]              val
);

   // Scan from the highest bus down so the lowest matching bus is written last.
   always_comb begin
      hit = 1'b0;
      val = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
         if (cdb_valid[k] && tag[ROB_W] && (tag[ROB_W-1:0] == cdb_rob_pos[k*ROB_W +: ROB_W])) begin
            hit = 1'b1;
            val = cdb_val[k*32 +: 32];
         end
      end
   end

endmodule

// File: rtl/lsb_queue_param.sv
// In-order load/store buffer: circular queue of issued memory ops with CDB
// operand wakeup, commit-gated stores, a single outstanding memory request
// and a one-entry last-store bypass for loads.
//
// Handshake: the buffer raises mc_en with mc_wr/mc_addr/mc_len/mc_w_data stable
// and holds them until the cycle the controller returns mc_done; mc_en is low
// from the following cycle, and a new request needs at least one idle cycle.
module lsb_queue_param
   import lsb_queue_param_pkg::*;
#(
   parameter int         DEPTH   = 16,
   parameter int         ROB_W   = ROB_W_DEF,
   parameter int         NUM_CDB = 2,
   parameter logic [1:0] IO_HI   = IO_HI_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       rollback,
   output logic                       nxt_full,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       issue,
   input  logic [ROB_W-1:0]           issue_rob_pos,
   input  logic                       issue_is_store,
   input  logic [2:0]                 issue_funct3,
   input  logic [31:0]                issue_rs1_val,
   input  logic [ROB_W:0]             issue_rs1_tag,
   input  logic [31:0]                issue_rs2_val,
   input  logic [ROB_W:0]             issue_rs2_tag,
   input  logic [31:0]                issue_imm,
   input  logic [NUM_CDB-1:0]         cdb_valid,
   input  logic [NUM_CDB*ROB_W-1:0]   cdb_rob_pos,
   input  logic [NUM_CDB*32-1:0]      cdb_val,
   input  logic                       commit_store,
   input  logic [ROB_W-1:0]           commit_rob_pos,
   input  logic [ROB_W-1:0]           head_rob_pos,
   output logic                       mc_en,
   output logic                       mc_wr,
   output logic [31:0]                mc_addr,
   output logic [2:0]                 mc_len,
   output logic [31:0]                mc_w_data,
   input  logic                       mc_done,
   input  logic [31:0]                mc_r_data,
   output logic                       result,
   output logic [ROB_W-1:0]           result_rob_pos,
   output logic [31:0]                result_val,
   output logic                       fsm_state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Entry storage
   logic [ROB_W-1:0] e_rob_pos   [DEPTH];
   logic             e_store     [DEPTH];
   logic [2:0]       e_funct3    [DEPTH];
   logic [31:0]      e_rs1_val   [DEPTH];
   logic [ROB_W:0]   e_rs1_tag   [DEPTH];
   logic [31:0]      e_rs2_val   [DEPTH];
   logic [ROB_W:0]   e_rs2_tag   [DEPTH];
   logic [31:0]      e_imm       [DEPTH];
   logic             e_committed [DEPTH];

   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] ncommit;

   // FSM and outstanding-request context
   lsb_state_t       state;
   logic             drop;
   logic [ROB_W-1:0] cur_rob_pos;
   logic [2:0]       cur_funct3;

   // Last-store bypass
   logic             byp_v;
   logic [31:0]      byp_addr;
   logic [2:0]       byp_len;
   logic [31:0]      byp_data;

   assign fsm_state = state;

   // ---------------------------------------------------------------- wakeup
   logic [DEPTH-1:0] wk1_hit, wk2_hit;
   logic [31:0]      wk1_val [DEPTH];
   logic [31:0]      wk2_val [DEPTH];
   logic             iw1_hit, iw2_hit;
   logic [31:0]      iw1_val, iw2_val;

   for (genvar g = 0; g < DEPTH; g++) begin : g_wake
      lsb_cdb_match #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_m1 (
         .tag(e_rs1_tag[g]), .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos),
         .cdb_val(cdb_val), .hit(wk1_hit[g]), .val(wk1_val[g]));
      lsb_cdb_match #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_m2 (
         .tag(e_rs2_tag[g]), .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos),
         .cdb_val(cdb_val), .hit(wk2_hit[g]), .val(wk2_val[g]));
   end

   // Operands arriving on a CDB in the issue cycle are captured directly.
   lsb_cdb_match #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_iss1 (
      .tag(issue_rs1_tag), .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos),
      .cdb_val(cdb_val), .hit(iw1_hit), .val(iw1_val));
   lsb_cdb_match #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_iss2 (
      .tag(issue_rs2_tag), .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos),
      .cdb_val(cdb_val), .hit(iw2_hit), .val(iw2_val));

   // ---------------------------------------------------------------- head view
   logic [31:0] h_addr;
   logic [2:0]  h_len;
   logic        h_io, h_ops_ok, h_ready, byp_hit;

   assign h_addr   = e_rs1_val[head] + e_imm[head];
   assign h_len    = len_of(e_funct3[head]);
   assign h_io     = is_io(h_addr, IO_HI);
   assign h_ops_ok = !e_rs1_tag[head][ROB_W] && (!e_store[head] || !e_rs2_tag[head][ROB_W]);
   assign h_ready  = (count != '0) && h_ops_ok &&
                     (e_store[head] ? e_committed[head]
                                    : (!rollback && (!h_io || (e_rob_pos[head] == head_rob_pos))));
   assign byp_hit  = !e_store[head] && byp_v && !h_io && (h_addr == byp_addr) && (h_len <= byp_len);

   // ---------------------------------------------------------------- control
   logic start_req, byp_pop, done, pop_store, pop_load, pop, push;
   logic commit_en, commit_hit;

   assign start_req = rdy && (state == ST_IDLE) && h_ready && !byp_hit;
   assign byp_pop   = rdy && (state == ST_IDLE) && h_ready && byp_hit;
   assign done      = rdy && (state == ST_WAIT) && mc_done;
   assign pop_store = done && mc_wr;
   assign pop_load  = done && !mc_wr && !drop && !rollback;
   assign pop       = pop_store || pop_load || byp_pop;
   assign push      = rdy && issue && !rollback && (count != CNT_W'(DEPTH));
   assign commit_en = commit_store && (rdy || rollback);

   logic [DEPTH-1:0] busy, cmt_match;
   logic [PTR_W-1:0] off;

   // Occupancy per slot and the slot a committing store refers to.
   always_comb begin
      busy      = '0;
      cmt_match = '0;
      off       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off          = PTR_W'(i) - head;
         busy[i]      = ({1'b0, off} < count);
         cmt_match[i] = busy[i] && e_store[i] && !e_committed[i] && (e_rob_pos[i] == commit_rob_pos);
      end
   end

   assign commit_hit = commit_en && (|cmt_match);

   logic [PTR_W-1:0] head_n;
   logic [CNT_W-1:0] ncommit_n;

   assign head_n    = head + PTR_W'(pop);
   assign ncommit_n = ncommit + CNT_W'(commit_hit) - CNT_W'(pop_store);
   assign nxt_full  = ((count + CNT_W'(push) - CNT_W'(pop)) == CNT_W'(DEPTH));

   // Entry storage: operand wakeup, commit marking, and the write of a new entry.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rdy && !rst) begin
            if (wk1_hit[i]) begin
               e_rs1_val[i] <= wk1_val[i];
               e_rs1_tag[i] <= '0;
            end
            if (wk2_hit[i]) begin
               e_rs2_val[i] <= wk2_val[i];
               e_rs2_tag[i] <= '0;
            end
         end
         if (!rst && commit_hit && cmt_match[i]) begin
            e_committed[i] <= 1'b1;
         end
         if (!rst && push && (tail == PTR_W'(i))) begin
            e_rob_pos[i]   <= issue_rob_pos;
            e_store[i]     <= issue_is_store;
            e_funct3[i]    <= issue_funct3;
            e_imm[i]       <= issue_imm;
            e_committed[i] <= 1'b0;
            e_rs1_val[i]   <= iw1_hit ? iw1_val : issue_rs1_val;
            e_rs1_tag[i]   <= iw1_hit ? '0 : issue_rs1_tag;
            e_rs2_val[i]   <= iw2_hit ? iw2_val : issue_rs2_val;
            e_rs2_tag[i]   <= iw2_hit ? '0 : issue_rs2_tag;
         end
      end
   end

   // Queue pointers, occupancy and committed-store count; rollback keeps only committed stores.
   always_ff @(posedge clk) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         ncommit <= '0;
      end else begin
         head    <= head_n;
         ncommit <= ncommit_n;
         if (rollback) begin
            tail  <= head_n + ncommit_n[PTR_W-1:0];
            count <= ncommit_n;
         end else begin
            tail  <= tail + PTR_W'(push);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Request FSM with registered memory-side and result outputs, plus bypass capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         drop           <= 1'b0;
         mc_en          <= 1'b0;
         mc_wr          <= 1'b0;
         mc_addr        <= '0;
         mc_len         <= '0;
         mc_w_data      <= '0;
         cur_rob_pos    <= '0;
         cur_funct3     <= '0;
         result         <= 1'b0;
         result_rob_pos <= '0;
         result_val     <= '0;
         byp_v          <= 1'b0;
         byp_addr       <= '0;
         byp_len        <= '0;
         byp_data       <= '0;
      end else begin
         result <= 1'b0;
         if (rdy) begin
            case (state)
               ST_IDLE: begin
                  if (start_req) begin
                     mc_en       <= 1'b1;
                     mc_wr       <= e_store[head];
                     mc_addr     <= h_addr;
                     mc_len      <= h_len;
                     mc_w_data   <= e_store[head] ? e_rs2_val[head] : 32'h0;
                     cur_rob_pos <= e_rob_pos[head];
                     cur_funct3  <= e_funct3[head];
                     drop        <= 1'b0;
                     state       <= ST_WAIT;
                  end else if (byp_pop) begin
                     result         <= 1'b1;
                     result_rob_pos <= e_rob_pos[head];
                     result_val     <= ext_load(e_funct3[head], byp_data);
                  end
               end
               ST_WAIT: begin
                  if (mc_done) begin
                     mc_en <= 1'b0;
                     mc_wr <= 1'b0;
                     drop  <= 1'b0;
                     state <= ST_IDLE;
                     if (mc_wr) begin
                        if (is_io(mc_addr, IO_HI)) begin
                           byp_v <= 1'b0;
                        end else begin
                           byp_v    <= 1'b1;
                           byp_addr <= mc_addr;
                           byp_len  <= mc_len;
                           byp_data <= mc_w_data;
                        end
                     end else if (!drop && !rollback) begin
                        result         <= 1'b1;
                        result_rob_pos <= cur_rob_pos;
                        result_val     <= ext_load(cur_funct3, mc_r_data);
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
         // A flushed outstanding load still runs to completion but is then discarded.
         if (rollback && (state == ST_WAIT) && !mc_wr && !done) begin
            drop <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lsb_queue_param.sv
// Directed bench for lsb_queue_param: table of load-extension vectors plus
// hand-written sequences for wakeup, bypass, full, rollback and I/O ordering.
module tb_lsb_queue_param;
   localparam int DEPTH   = 16;
   localparam int ROB_W   = 4;
   localparam int NUM_CDB = 2;

   logic              clk = 1'b0;
   logic              rst, rdy, rollback;
   logic              nxt_full;
   logic [4:0]        count;
   logic              issue, issue_is_store;
   logic [3:0]        issue_rob_pos;
   logic [2:0]        issue_funct3;
   logic [31:0]       issue_rs1_val, issue_rs2_val, issue_imm;
   logic [4:0]        issue_rs1_tag, issue_rs2_tag;
   logic [1:0]        cdb_valid;
   logic [7:0]        cdb_rob_pos;
   logic [63:0]       cdb_val;
   logic              commit_store;
   logic [3:0]        commit_rob_pos, head_rob_pos;
   logic              mc_en, mc_wr, mc_done;
   logic [31:0]       mc_addr, mc_w_data, mc_r_data;
   logic [2:0]        mc_len;
   logic              result;
   logic [3:0]        result_rob_pos;
   logic [31:0]       result_val;
   logic              fsm_state;

   int n_vec = 0;
   int n_bad = 0;

   lsb_queue_param #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .nxt_full(nxt_full), .count(count),
      .issue(issue), .issue_rob_pos(issue_rob_pos), .issue_is_store(issue_is_store),
      .issue_funct3(issue_funct3), .issue_rs1_val(issue_rs1_val), .issue_rs1_tag(issue_rs1_tag),
      .issue_rs2_val(issue_rs2_val), .issue_rs2_tag(issue_rs2_tag), .issue_imm(issue_imm),
      .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
      .commit_store(commit_store), .commit_rob_pos(commit_rob_pos), .head_rob_pos(head_rob_pos),
      .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len), .mc_w_data(mc_w_data),
      .mc_done(mc_done), .mc_r_data(mc_r_data), .result(result), .result_rob_pos(result_rob_pos),
      .result_val(result_val), .fsm_state(fsm_state));

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Load-extension vector table
   typedef struct {
      logic [2:0]  f3;
      logic [31:0] rs1;
      logic [31:0] imm;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic [2:0]  exp_len;
      logic [31:0] exp_val;
   } ld_vec_t;
   ld_vec_t vt [7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_issue(input logic st, input logic [3:0] pos, input logic [2:0] f3,
                           input logic [31:0] rs1v, input logic [4:0] rs1t,
                           input logic [31:0] rs2v, input logic [31:0] imm);
      issue          = 1'b1;
      issue_is_store = st;
      issue_rob_pos  = pos;
      issue_funct3   = f3;
      issue_rs1_val  = rs1v;
      issue_rs1_tag  = rs1t;
      issue_rs2_val  = rs2v;
      issue_rs2_tag  = '0;
      issue_imm      = imm;
      step();
      issue = 1'b0;
   endtask

   task automatic wait_mc(input string name);
      int n;
      n = 0;
      while (!mc_en && n < 20) begin
         step();
         n++;
      end
      chk({name, "_mc_en_seen"}, {31'b0, mc_en}, 32'd1);
   endtask

   task automatic serve(input logic [31:0] rdata);
      mc_done   = 1'b1;
      mc_r_data = rdata;
      step();
      mc_done   = 1'b0;
      mc_r_data = '0;
   endtask

   task automatic commit(input logic [3:0] pos);
      commit_store   = 1'b1;
      commit_rob_pos = pos;
      step();
      commit_store = 1'b0;
   endtask

   initial begin
      logic got, saw_mc;

      vt[0] = '{3'b010, 32'h0000_0100, 32'h0000_0004, 32'h8000_00FF, 32'h0000_0104, 3'd4, 32'h8000_00FF};
      vt[1] = '{3'b000, 32'h0000_0200, 32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_01FF, 3'd1, 32'hFFFF_FF80};
      vt[2] = '{3'b100, 32'h0000_0300, 32'h0000_0010, 32'h0000_0080, 32'h0000_0310, 3'd1, 32'h0000_0080};
      vt[3] = '{3'b001, 32'h0000_0400, 32'h0000_0002, 32'h0000_8001, 32'h0000_0402, 3'd2, 32'hFFFF_8001};
      vt[4] = '{3'b101, 32'h0000_0500, 32'h0000_0000, 32'h0000_8001, 32'h0000_0500, 3'd2, 32'h0000_8001};
      vt[5] = '{3'b001, 32'h0000_0600, 32'h0000_0000, 32'h0000_7FFF, 32'h0000_0600, 3'd2, 32'h0000_7FFF};
      vt[6] = '{3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'h1234_5678, 32'h0000_0004, 3'd4, 32'h1234_5678};

      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue = 1'b0; issue_is_store = 1'b0;
      issue_rob_pos = '0; issue_funct3 = '0; issue_rs1_val = '0; issue_rs1_tag = '0;
      issue_rs2_val = '0; issue_rs2_tag = '0; issue_imm = '0; cdb_valid = '0;
      cdb_rob_pos = '0; cdb_val = '0; commit_store = 1'b0; commit_rob_pos = '0;
      head_rob_pos = '0; mc_done = 1'b0; mc_r_data = '0;
      repeat (3) step();
      rst = 1'b0;

      // Reset state
      chk("rst_mc_en", {31'b0, mc_en}, 32'd0);
      chk("rst_result", {31'b0, result}, 32'd0);
      chk("rst_count", {27'b0, count}, 32'd0);
      chk("rst_nxt_full", {31'b0, nxt_full}, 32'd0);
      chk("rst_state", {31'b0, fsm_state}, 32'd0);

      // Table: ready loads, address generation and extension
      for (int i = 0; i < 7; i++) begin
         do_issue(1'b0, 4'(i + 1), vt[i].f3, vt[i].rs1, 5'd0, 32'd0, vt[i].imm);
         wait_mc("vec");
         chk($sformatf("vec%0d_addr", i), mc_addr, vt[i].exp_addr);
         chk($sformatf("vec%0d_len", i), {29'b0, mc_len}, {29'b0, vt[i].exp_len});
         chk($sformatf("vec%0d_wr", i), {31'b0, mc_wr}, 32'd0);
         serve(vt[i].rdata);
         chk($sformatf("vec%0d_result", i), {31'b0, result}, 32'd1);
         chk($sformatf("vec%0d_val", i), result_val, vt[i].exp_val);
         chk($sformatf("vec%0d_rob", i), {28'b0, result_rob_pos}, i + 1);
         step();
         chk($sformatf("vec%0d_pulse", i), {31'b0, result}, 32'd0);
      end

      // Wakeup on CDB1
      do_issue(1'b0, 4'd11, 3'b000, 32'd0, 5'b1_0011, 32'd0, 32'd0);
      step(); step();
      chk("wake_no_mc_before", {31'b0, mc_en}, 32'd0);
      cdb_valid = 2'b10; cdb_rob_pos = {4'd3, 4'd0}; cdb_val = {32'h0000_0010, 32'h0};
      step();
      cdb_valid = '0;
      wait_mc("wake");
      chk("wake_addr", mc_addr, 32'h0000_0010);
      serve(32'h0000_0080);
      chk("wake_val", result_val, 32'hFFFF_FF80);

      // Two buses match: the lower bus wins
      do_issue(1'b0, 4'd12, 3'b100, 32'd0, 5'b1_0101, 32'd0, 32'd0);
      cdb_valid = 2'b11; cdb_rob_pos = {4'd5, 4'd5}; cdb_val = {32'h0000_0044, 32'h0000_0040};
      step();
      cdb_valid = '0;
      wait_mc("prio");
      chk("prio_addr", mc_addr, 32'h0000_0040);
      serve(32'h0000_007F);
      chk("prio_val", result_val, 32'h0000_007F);

      // CDB broadcast in the issue cycle
      cdb_valid = 2'b01; cdb_rob_pos = {4'd0, 4'd6}; cdb_val = {32'h0, 32'h0000_0050};
      do_issue(1'b0, 4'd13, 3'b010, 32'd0, 5'b1_0110, 32'd0, 32'd4);
      cdb_valid = '0;
      wait_mc("isscap");
      chk("isscap_addr", mc_addr, 32'h0000_0054);
      serve(32'h0000_0011);
      chk("isscap_val", result_val, 32'h0000_0011);

      // Store waits for commit, then feeds the bypass
      do_issue(1'b1, 4'd7, 3'b010, 32'h0000_0020, 5'd0, 32'h1234_5678, 32'd0);
      repeat (3) step();
      chk("st_wait_commit", {31'b0, mc_en}, 32'd0);
      commit(4'd7);
      wait_mc("st");
      chk("st_wr", {31'b0, mc_wr}, 32'd1);
      chk("st_addr", mc_addr, 32'h0000_0020);
      chk("st_data", mc_w_data, 32'h1234_5678);
      chk("st_len", {29'b0, mc_len}, 32'd4);
      serve(32'd0);
      chk("st_no_result", {31'b0, result}, 32'd0);
      do_issue(1'b0, 4'd8, 3'b101, 32'h0000_0020, 5'd0, 32'd0, 32'd0);
      got = 1'b0; saw_mc = 1'b0;
      for (int k = 0; k < 5 && !got; k++) begin
         step();
         if (mc_en) saw_mc = 1'b1;
         if (result) begin
            got = 1'b1;
            chk("byp_val", result_val, 32'h0000_5678);
            chk("byp_rob", {28'b0, result_rob_pos}, 32'd8);
         end
      end
      chk("byp_seen", {31'b0, got}, 32'd1);
      chk("byp_no_mc", {31'b0, saw_mc}, 32'd0);
      chk("byp_count", {27'b0, count}, 32'd0);

      // Fill to DEPTH with uncommitted stores
      for (int i = 0; i < DEPTH; i++) begin
         issue = 1'b1; issue_is_store = 1'b1; issue_rob_pos = 4'(i); issue_funct3 = 3'b010;
         issue_rs1_val = 32'h0000_1000 + 32'(i * 4); issue_rs1_tag = '0;
         issue_rs2_val = 32'hA000_0000 + 32'(i); issue_rs2_tag = '0; issue_imm = '0;
         if (i == DEPTH - 2) begin
            #1;
            chk("fill_nxt_full_early", {31'b0, nxt_full}, 32'd0);
         end
         if (i == DEPTH - 1) begin
            #1;
            chk("fill_nxt_full_last", {31'b0, nxt_full}, 32'd1);
         end
         step();
      end
      issue = 1'b0;
      chk("full_count", {27'b0, count}, DEPTH);
      chk("full_nxt_full", {31'b0, nxt_full}, 32'd1);
      do_issue(1'b1, 4'd15, 3'b010, 32'h0000_2000, 5'd0, 32'hDEAD_BEEF, 32'd0);
      chk("full_ignored_count", {27'b0, count}, DEPTH);
      commit(4'd0);
      wait_mc("full_pop");
      chk("full_head_addr", mc_addr, 32'h0000_1000);
      chk("full_head_data", mc_w_data, 32'hA000_0000);
      mc_done = 1'b1;
      #1;
      chk("pop_nxt_full", {31'b0, nxt_full}, 32'd0);
      step();
      mc_done = 1'b0;
      chk("pop_count", {27'b0, count}, DEPTH - 1);
      chk("pop_nxt_full_after", {31'b0, nxt_full}, 32'd0);
      rollback = 1'b1;
      step();
      rollback = 1'b0;
      chk("rb_empty_count", {27'b0, count}, 32'd0);

      // rdy low: issue is ignored
      rdy = 1'b0;
      do_issue(1'b0, 4'd1, 3'b010, 32'h0000_0300, 5'd0, 32'd0, 32'd0);
      rdy = 1'b1;
      chk("rdy_low_count", {27'b0, count}, 32'd0);

      // Two committed stores and three loads, then rollback
      do_issue(1'b1, 4'd1, 3'b010, 32'h0000_0040, 5'd0, 32'hAAAA_0001, 32'd0);
      do_issue(1'b1, 4'd2, 3'b010, 32'h0000_0044, 5'd0, 32'hBBBB_0002, 32'd0);
      do_issue(1'b0, 4'd3, 3'b010, 32'h0000_0080, 5'd0, 32'd0, 32'd0);
      do_issue(1'b0, 4'd4, 3'b010, 32'h0000_0084, 5'd0, 32'd0, 32'd0);
      do_issue(1'b0, 4'd5, 3'b010, 32'h0000_0088, 5'd0, 32'd0, 32'd0);
      commit(4'd1);
      commit(4'd2);
      rollback = 1'b1;
      step();
      rollback = 1'b0;
      chk("rb_count", {27'b0, count}, 32'd2);
      wait_mc("rb_s1");
      chk("rb_s1_addr", mc_addr, 32'h0000_0040);
      chk("rb_s1_data", mc_w_data, 32'hAAAA_0001);
      serve(32'd0);
      chk("rb_s1_no_result", {31'b0, result}, 32'd0);
      wait_mc("rb_s2");
      chk("rb_s2_addr", mc_addr, 32'h0000_0044);
      chk("rb_s2_data", mc_w_data, 32'hBBBB_0002);
      serve(32'd0);
      got = 1'b0; saw_mc = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (result) got = 1'b1;
         if (mc_en) saw_mc = 1'b1;
         step();
      end
      chk("rb_no_load_result", {31'b0, got}, 32'd0);
      chk("rb_no_load_mc", {31'b0, saw_mc}, 32'd0);
      chk("rb_final_count", {27'b0, count}, 32'd0);

      // Rollback while a load is outstanding
      do_issue(1'b0, 4'd10, 3'b010, 32'h0000_0090, 5'd0, 32'd0, 32'd0);
      wait_mc("drop");
      rollback = 1'b1;
      step();
      rollback = 1'b0;
      chk("drop_mc_held", {31'b0, mc_en}, 32'd1);
      chk("drop_count", {27'b0, count}, 32'd0);
      serve(32'h0000_DEAD);
      chk("drop_no_result", {31'b0, result}, 32'd0);
      chk("drop_mc_off", {31'b0, mc_en}, 32'd0);
      chk("drop_idle", {31'b0, fsm_state}, 32'd0);
      step();
      chk("drop_count_after", {27'b0, count}, 32'd0);

      // I/O load waits for head_rob_pos
      head_rob_pos = 4'd4;
      do_issue(1'b0, 4'd9, 3'b010, 32'h0003_0000, 5'd0, 32'd0, 32'd0);
      repeat (3) step();
      chk("io_blocked", {31'b0, mc_en}, 32'd0);
      head_rob_pos = 4'd9;
      wait_mc("io");
      chk("io_addr", mc_addr, 32'h0003_0000);
      serve(32'h0000_00AB);
      chk("io_val", result_val, 32'h0000_00AB);
      chk("io_rob", {28'b0, result_rob_pos}, 32'd9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
